// File: rtl/regfile_scoreboard.sv
// Register file with two write ports, two read ports and a busy scoreboard.
// A busy bit marks a register whose producer has not yet written it back.
// Reserving a register sets its busy bit, and writing it clears the bit.
// When a reserve and a write hit the same register, the reserve wins.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic              busy0,
  output logic              busy1,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wa_ok;
  logic              wb_ok;
  logic              rsv_ok;

  // Qualify each request: when ZERO_REG is set, requests to register 0 are dropped
  always_comb begin
    wa_ok  = wr_en_a && !((ZERO_REG != 0) && (wr_addr_a == '0));
    wb_ok  = wr_en_b && !((ZERO_REG != 0) && (wr_addr_b == '0));
    rsv_ok = rsv_en  && !((ZERO_REG != 0) && (rsv_addr  == '0));
  end

  // Next busy vector: writes clear first, then a reserve sets, so reserve wins
  always_comb begin
    busy_nxt = busy;
    if (wa_ok)  busy_nxt[wr_addr_a] = 1'b0;
    if (wb_ok)  busy_nxt[wr_addr_b] = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr]  = 1'b1;
  end

  // Population count of the next busy vector, registered alongside it
  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  // Data array: port B is applied after port A, so B wins a collision
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wa_ok) mem[wr_addr_a] <= wr_data_a;
      if (wb_ok) mem[wr_addr_b] <= wr_data_b;
    end
  end

  // Scoreboard state and its registered count
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Read port 0: forward same-cycle write data (B before A), else read the array
  always_comb begin
    rd_data0 = '0;
    busy0    = 1'b0;
    if (rst) begin
      if ((BYPASS != 0) && wb_ok && (wr_addr_b == rd_addr0)) begin
        rd_data0 = wr_data_b;
      end else if ((BYPASS != 0) && wa_ok && (wr_addr_a == rd_addr0)) begin
        rd_data0 = wr_data_a;
      end else if (!((ZERO_REG != 0) && (rd_addr0 == '0))) begin
        rd_data0 = mem[rd_addr0];
        busy0    = busy[rd_addr0];
      end
    end
  end

  // Read port 1: same rules as port 0
  always_comb begin
    rd_data1 = '0;
    busy1    = 1'b0;
    if (rst) begin
      if ((BYPASS != 0) && wb_ok && (wr_addr_b == rd_addr1)) begin
        rd_data1 = wr_data_b;
      end else if ((BYPASS != 0) && wa_ok && (wr_addr_a == rd_addr1)) begin
        rd_data1 = wr_data_a;
      end else if (!((ZERO_REG != 0) && (rd_addr1 == '0))) begin
        rd_data1 = mem[rd_addr1];
        busy1    = busy[rd_addr1];
      end
    end
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have these parameters:
  - DATA_W, default 32, register width in bits.
  - ADDR_W, default 5, address width; depth is NREG = 2**ADDR_W.
  - ZERO_REG, default 1, where 1 means register 0 is hard-wired to zero and never busy.
  - BYPASS, default 1, where 1 means same-cycle write data is forwarded to read ports.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  - clk  in  1  single clock; all state updates on rising edge.
  - rst  in  1  synchronous, active-low reset.
  - rd_addr0  in  ADDR_W  read port 0 address.
  - rd_addr1  in  ADDR_W  read port 1 address.
  - rd_data0  out  DATA_W  read port 0 data.
  - rd_data1  out  DATA_W  read port 1 data.
  - busy0  out  1  pending-write status of rd_addr0.
  - busy1  out  1  pending-write status of rd_addr1.
  - wr_en_a  in  1  write port A enable.
  - wr_addr_a  in  ADDR_W  write port A address.
  - wr_data_a  in  DATA_W  write port A data.
  - wr_en_b  in  1  write port B enable.
  - wr_addr_b  in  ADDR_W  write port B address.
  - wr_data_b  in  DATA_W  write port B data.
  - rsv_en  in  1  reserve request; marks a destination as pending.
  - rsv_addr  in  ADDR_W  address to reserve.
  - busy_cnt  out  ADDR_W+1  number of currently busy registers.

Function
REQ-003 Storage: NREG x DATA_W data array plus an NREG-bit busy vector, both updated only on rising clk.
REQ-004 Writes: wr_en_x=1 writes wr_data_x to wr_addr_x at the edge; both ports may write in the same cycle.
REQ-005 Write collision: if both ports are enabled to the same address, port B's data SHALL be stored.
REQ-006 Zero register: with ZERO_REG=1, writes to address 0 are discarded; reads of 0 return 0; busy[0] stays 0.
REQ-007 Reads: rd_dataN is combinational from the array (0-cycle latency); both ports may read the same address.
REQ-008 Bypass: with BYPASS=1, a read address matching an enabled, non-discarded write in the same cycle SHALL return that write data; if both ports match, port B's data is returned.
REQ-009 No bypass: with BYPASS=0, reads return pre-edge array contents; new data is visible one cycle after the write.
REQ-010 Reserve: rsv_en=1 sets busy[rsv_addr] at the edge; reserving an already busy register leaves it busy, with no error.
REQ-011 Clear: an enabled write on either port clears busy[wr_addr] at the edge; writing a non-busy register is legal and leaves it clear.
REQ-012 Reserve and write in the same cycle to the same address: the reserve SHALL win (busy ends at 1, data is still written), which models a new producer.
REQ-013 busyN = busy[rd_addrN]; with BYPASS=1, busyN is forced to 0 when a same-cycle write to rd_addrN is being bypassed.
REQ-014 busy_cnt is the registered population count of the busy vector, updated the same edge as the vector; range 0..NREG (NREG only if ZERO_REG=0).

Reset
REQ-015 When rst=0 at a rising edge, all registers SHALL clear to 0, all busy bits SHALL clear to 0, busy_cnt SHALL become 0, and writes and reserves that cycle are ignored.
REQ-016 While rst=0, rd_data0, rd_data1, busy0 and busy1 SHALL be driven 0, with no bypass.
REQ-017 Reset asserted mid-operation SHALL discard all pending reservations; no state survives.
REQ-018 The first edge with rst=1 SHALL accept writes and reserves normally.

Verification
REQ-019 Reset then read all addresses -> every rd_data is 0, busy0=busy1=0, busy_cnt=0.
REQ-020 Write A r5=0x1234 and B r5=0xBEEF in the same cycle, read r5 next cycle -> 0xBEEF; with BYPASS=1, same-cycle read returns 0xBEEF.
REQ-021 Write r0=0xFFFFFFFF (ZERO_REG=1), read r0 -> 0; reserve r0 -> busy0=0, busy_cnt unchanged.
REQ-022 Reserve r3, r7 -> busy_cnt=2; write r3 -> busy_cnt=1, busy for r3=0; in the same cycle, reserve r7 and write r7 -> busy for r7 stays 1, r7 data is updated.
REQ-023 BYPASS=0 build: write r9=0xA5A5A5A5 with same-cycle read of r9 -> old value; next cycle -> 0xA5A5A5A5.
REQ-024 Reserve r1, write r2=0x55, then assert rst=0 for one edge -> r2=0, busy_cnt=0; first post-reset write succeeds.
